// File: rtl/joystick_step_ctrl.sv
// joystick_step_ctrl: debounced joystick buttons to per-axis udl_counter step, auto-repeat and home-load controls
module joystick_step_ctrl #(
  parameter int BITS            = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FIRST_DELAY     = 25_000_000,
  parameter int REPEAT_PERIOD   = 2_000_000,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int X_HOME          = 320,
  parameter int Y_HOME          = 240
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_l,
  input  logic            btn_r,
  input  logic            btn_u,
  input  logic            btn_d,
  input  logic            btn_c,
  input  logic [BITS-1:0] x_pos,
  input  logic [BITS-1:0] y_pos,
  output logic            x_en,
  output logic            y_en,
  output logic            x_up,
  output logic            y_up,
  output logic            x_load,
  output logic            y_load,
  output logic [BITS-1:0] x_d,
  output logic [BITS-1:0] y_d
);
  localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = FIRST_DELAY > REPEAT_PERIOD ? FIRST_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  logic [4:0] btn, s1, s2, stb;
  logic [DW-1:0] cnt [5];
  logic c_q, c_rise;
  logic [1:0] vld, dir, blk, fire, dq, en, up, ld;
  logic [TW-1:0] tmr [2];
  state_t st [2];
  assign btn = {btn_c, btn_d, btn_u, btn_r, btn_l};
  assign c_rise = stb[4] & ~c_q;
  // a change is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk)
    if (!reset) begin
      s1  <= '0;
      s2  <= '0;
      stb <= '0;
      c_q <= 1'b0;
      for (int k = 0; k < 5; k++) cnt[k] <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      c_q <= stb[4];
      for (int k = 0; k < 5; k++) begin
        cnt[k] <= (s2[k] == stb[k] || cnt[k] == DMAX) ? '0 : cnt[k] + 1'b1;
        if (s2[k] != stb[k] && cnt[k] == DMAX) stb[k] <= ~stb[k];
      end
    end
  always_comb begin
    vld    = {stb[2] ^ stb[3], stb[0] ^ stb[1]};
    dir    = {stb[3], stb[1]};
    blk[0] = dir[0] ? x_pos >= BITS'(X_MAX) : x_pos <= BITS'(X_MIN);
    blk[1] = dir[1] ? y_pos >= BITS'(Y_MAX) : y_pos <= BITS'(Y_MIN);
    for (int a = 0; a < 2; a++)
      fire[a] = vld[a] & (st[a] == IDLE | (dq[a] == dir[a] & tmr[a] == '0));
  end
  // clamped steps are dropped but the FSM still advances; a centre load overrides any step
  always_ff @(posedge clk)
    if (!reset) begin
      st  <= '{IDLE, IDLE};
      tmr <= '{default: '0};
      dq  <= '0;
      en  <= '0;
      up  <= '0;
      ld  <= '0;
    end else begin
      en <= fire & ~blk & ~{2{c_rise}} | {2{c_rise}};
      up <= fire & ~blk & dir & ~{2{c_rise}};
      ld <= {2{c_rise}};
      for (int a = 0; a < 2; a++)
        if (st[a] == IDLE) begin
          if (vld[a]) begin
            st[a]  <= DELAY;
            tmr[a] <= TW'(FIRST_DELAY - 1);
            dq[a]  <= dir[a];
          end
        end else if (!vld[a] || dir[a] != dq[a]) st[a] <= IDLE;
        else if (tmr[a] == '0) begin
          st[a]  <= REPEAT;
          tmr[a] <= TW'(REPEAT_PERIOD - 1);
        end else tmr[a] <= tmr[a] - 1'b1;
    end
  assign x_en   = en[0];
  assign y_en   = en[1];
  assign x_up   = up[0];
  assign y_up   = up[1];
  assign x_load = ld[0];
  assign y_load = ld[1];
  assign x_d    = BITS'(X_HOME);
  assign y_d    = BITS'(Y_HOME);
endmodule

// File: tb/tb_joystick_step_ctrl.sv
// tb_joystick_step_ctrl: directed stimulus with a queue of expected output pulses checked at each DUT pulse
module tb_joystick_step_ctrl;
  logic clk = 0, reset = 0;
  logic btn_l = 0, btn_r = 0, btn_u = 0, btn_d = 0, btn_c = 0;
  logic [3:0] x_pos = 4'd5, y_pos = 4'd10;
  logic x_en, y_en, x_up, y_up, x_load, y_load;
  logic [3:0] x_d, y_d;
  logic [5:0] ov;
  int cyc = 0, checks = 0, errors = 0, k;
  typedef struct {int c; logic [5:0] v; logic [5:0] m;} ev_t;
  ev_t q[$];
  ev_t e;
  joystick_step_ctrl #(
    .BITS(4), .DEBOUNCE_CYCLES(4), .FIRST_DELAY(8), .REPEAT_PERIOD(4),
    .X_MIN(2), .X_MAX(12), .Y_MIN(0), .Y_MAX(15), .X_HOME(7), .Y_HOME(7)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c),
    .x_pos(x_pos), .y_pos(y_pos),
    .x_en(x_en), .y_en(y_en), .x_up(x_up), .y_up(y_up),
    .x_load(x_load), .y_load(y_load), .x_d(x_d), .y_d(y_d)
  );
  assign ov = {x_en, x_up, x_load, y_en, y_up, y_load};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(int c, logic [5:0] v, logic [5:0] m = 6'h3f);
    q.push_back('{c, v, m});
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic drain(string tag);
    checks++;
    assert (q.size() === 0) else begin
      errors++;
      $error("FAIL %s pending_pulses obs=%0d exp=0", tag, q.size());
    end
    q.delete();
  endtask
  always @(negedge clk)
    if (x_en || y_en) begin
      checks++;
      if (q.size() == 0) begin
        assert (ov === 6'h00) else begin
          errors++;
          $error("FAIL unexpected_pulse cyc=%0d obs=%b exp=%b", cyc, ov, 6'h00);
        end
      end else begin
        e = q.pop_front();
        assert ({cyc, ov & e.m} === {e.c, e.v & e.m}) else begin
          errors++;
          $error("FAIL pulse obs=cyc%0d/%b exp=cyc%0d/%b", cyc, ov & e.m, e.c, e.v & e.m);
        end
      end
    end
  initial begin
    {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b11111;
    repeat (5) begin
      @(negedge clk);
      checks++;
      assert (ov === 6'h00) else begin
        errors++;
        $error("FAIL reset_outputs obs=%b exp=%b", ov, 6'h00);
      end
    end
    checks++;
    assert ({x_d, y_d} === {4'd7, 4'd7}) else begin
      errors++;
      $error("FAIL home_values obs=%h exp=%h", {x_d, y_d}, 8'h77);
    end
    reset = 1;
    {btn_l, btn_r, btn_u, btn_d, btn_c} = 5'b00000;
    tick(12);
    drain("idle");
    k = cyc; btn_r = 1; push(k + 7, 6'b110000);
    tick(6); btn_r = 0; tick(30);
    drain("tap");
    k = cyc; btn_u = 1;
    push(k + 7, 6'b000100); push(k + 15, 6'b000100);
    for (int t = 19; t <= 43; t += 4) push(k + t, 6'b000100);
    tick(40); btn_u = 0; tick(30);
    drain("hold");
    y_pos = 4'd14; k = cyc; btn_d = 1; push(k + 7, 6'b000110);
    tick(6); btn_d = 0; tick(30);
    drain("y_down");
    y_pos = 4'd15; btn_d = 1; tick(20); btn_d = 0; tick(20);
    drain("y_clamp_max");
    x_pos = 4'd12; k = cyc; btn_r = 1;
    tick(17); x_pos = 4'd11; push(k + 19, 6'b110000); push(k + 23, 6'b110000);
    tick(3); btn_r = 0; tick(30);
    drain("clamp");
    x_pos = 4'd2; btn_l = 1; tick(20); btn_l = 0; tick(20);
    drain("clamp_min");
    x_pos = 4'd5;
    repeat (10) begin btn_l = ~btn_l; tick(2); end
    btn_l = 0; tick(20);
    drain("bounce");
    btn_l = 1; btn_r = 1; tick(20); btn_l = 0; btn_r = 0; tick(20);
    drain("both_lr");
    k = cyc; btn_r = 1;
    push(k + 7, 6'b110000); push(k + 15, 6'b110000);
    push(k + 19, 6'b101101, 6'b101101);
    push(k + 23, 6'b110000); push(k + 27, 6'b110000);
    tick(12); btn_c = 1; tick(8); btn_c = 0; tick(4); btn_r = 0; tick(30);
    drain("centre");
    k = cyc; btn_r = 1; push(k + 7, 6'b110000);
    tick(10); reset = 0; tick(3); reset = 1; push(k + 20, 6'b110000);
    tick(8); btn_r = 0; tick(30);
    drain("reset_mid_hold");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
